counter_driver: RTL and testbench

Synthesizable command-driven initiator for the 4-bit up-counter's control interface (`enable`, `preload`, `preload_val`). It also checks the counter's outputs (`detect`, `result`).
- A host issues PRELOAD / RUN / HOLD / NOP commands over a valid/ready port.
- The block drives the counter pins cycle-accurately, tracks the expected count in a reference model and compares every cycle.
- It returns one response per command: wrap count, last result, error flag.
- It replaces hand-written stimulus tasks when the counter is exercised in silicon-style self-test or emulation.

---
 rtl/counter_drv_pkg.sv | 25 ++
 rtl/counter_ref_model.sv | 37 +++
 rtl/counter_driver.sv | 140 ++++++++++++++
 tb/tb_counter_driver.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_drv_pkg.sv
// Shared types and default sizes for the counter driver.
// Imported by the driver top and its reference model.
package counter_drv_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_COUNT = 15;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PRELOAD = 2'd1,
    OP_RUN     = 2'd2,
    OP_HOLD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_RUN     = 3'd2,
    S_HOLD    = 3'd3,
    S_CHECK   = 3'd4,
    S_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/counter_ref_model.sv
// Cycle-accurate reference of the up-counter driven by this block.
// Updates on the same edge as the real counter.
module counter_ref_model
  import counter_drv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             preload,
  input  logic [WIDTH-1:0] preload_val,
  output logic [WIDTH-1:0] exp,
  output logic             exp_detect
);

  localparam logic [WIDTH-1:0] MAXV =
    WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp <= '0;
    end else if (preload) begin
      r_exp <= preload_val;
    end else if (enable) begin
      r_exp <= (r_exp == MAXV) ? '0
                               : r_exp + 1'b1;
    end
  end

  assign exp        = r_exp;
  assign exp_detect = (r_exp == MAXV);

endmodule

// File: rtl/counter_driver.sv
// Command-driven initiator and checker for the 4-bit up-counter.
// One response per command: wraps, sampled result, error flag.
module counter_driver
  import counter_drv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  output logic             enable,
  output logic             preload,
  output logic [WIDTH-1:0] preload_val,
  input  logic             detect,
  input  logic [WIDTH-1:0] result,
  output logic             rsp_valid,
  output logic [CNT_W-1:0] rsp_wraps,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wraps;
  logic [WIDTH-1:0] r_pval;
  logic [WIDTH-1:0] r_res;
  logic             r_err;
  logic             r_ierr;
  logic [WIDTH-1:0] w_exp;
  logic             w_exp_det;
  logic             w_idle;
  logic             w_acc;
  logic             w_mis;

  counter_ref_model #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_ref (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .preload     (preload),
    .preload_val (preload_val),
    .exp         (w_exp),
    .exp_detect  (w_exp_det)
  );

  assign w_idle      = (r_state == S_IDLE);
  assign cmd_ready   = w_idle && !rst;
  assign w_acc       = cmd_valid && cmd_ready;
  assign enable      = (r_state == S_RUN);
  assign preload     = (r_state == S_PRELOAD);
  assign preload_val = r_pval;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_wraps   = r_wraps;
  assign rsp_result  = r_res;
  assign rsp_error   = r_err;
  assign busy        = !w_idle;
  assign w_mis       = (result != w_exp) ||
                       (detect != w_exp_det);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          unique case (op_e'(cmd_op))
            OP_PRELOAD: w_next = S_PRELOAD;
            OP_RUN:
              w_next = (cmd_arg == '0) ? S_CHECK
                                       : S_RUN;
            OP_HOLD:
              w_next = (cmd_arg == '0) ? S_CHECK
                                       : S_HOLD;
            default:    w_next = S_RESP;
          endcase
        end
      end
      S_RUN, S_HOLD: begin
        if (r_cnt == CNT_W'(1)) w_next = S_CHECK;
      end
      S_PRELOAD: w_next = S_CHECK;
      S_CHECK:   w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pval  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cnt <= cmd_arg;
        if (op_e'(cmd_op) == OP_PRELOAD)
          r_pval <= cmd_arg[WIDTH-1:0];
      end else if (r_state == S_RUN ||
                   r_state == S_HOLD) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // IDLE mismatches park in r_ierr and fold into the next command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_ierr  <= 1'b0;
      r_wraps <= '0;
      r_res   <= '0;
    end else begin
      if (w_acc) begin
        r_err  <= r_ierr | w_mis;
        r_ierr <= 1'b0;
      end else if (w_idle) begin
        r_ierr <= r_ierr | w_mis;
      end else begin
        r_err <= r_err | w_mis;
      end
      if (w_acc) begin
        r_wraps <= '0;
      end else if (enable && w_exp_det &&
                   r_wraps != '1) begin
        r_wraps <= r_wraps + 1'b1;
      end
      if (r_state == S_CHECK) r_res <= result;
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Scoreboard bench for counter_driver with a behavioural counter.
// Counter can be faulted with result[0] stuck at 0.
module tb_counter_driver;

  typedef struct {
    int wraps;
    int res;
    int err;
    int lat;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       enable;
  logic       preload;
  logic [3:0] preload_val;
  logic       detect;
  logic [3:0] result;
  logic       rsp_valid;
  logic [7:0] rsp_wraps;
  logic [3:0] rsp_result;
  logic       rsp_error;
  logic       busy;
  logic       fault;
  logic [3:0] r_cnt;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   acc_q[$];

  counter_driver dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .enable      (enable),
    .preload     (preload),
    .preload_val (preload_val),
    .detect      (detect),
    .result      (result),
    .rsp_valid   (rsp_valid),
    .rsp_wraps   (rsp_wraps),
    .rsp_result  (rsp_result),
    .rsp_error   (rsp_error),
    .busy        (busy)
  );

  always_ff @(posedge clk) begin
    if (rst)          r_cnt <= 4'd0;
    else if (preload) r_cnt <= preload_val;
    else if (enable)  r_cnt <= r_cnt + 4'd1;
  end
  assign result = fault ? {r_cnt[3:1], 1'b0}
                        : r_cnt;
  assign detect = (r_cnt == 4'hF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready)
      acc_q.push_back(cyc + 1);
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm,
                     input int act,
                     input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d",
               nm, act, expv);
    end
  endtask

  exp_t m_e;
  int   m_a;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", int'(rsp_valid), 0);
      end else begin
        m_e = sb.pop_front();
        m_a = (acc_q.size() > 0) ?
              acc_q.pop_front() : -1000;
        chk("rsp_wraps", int'(rsp_wraps), m_e.wraps);
        chk("rsp_result", int'(rsp_result), m_e.res);
        chk("rsp_error", int'(rsp_error), m_e.err);
        chk("rsp_latency", cyc - m_a, m_e.lat);
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input int arg,
                       input bit push,
                       input int ew,
                       input int er,
                       input int ee,
                       input int lat);
    int   n;
    exp_t e;
    n = 0;
    if (push) begin
      e.wraps = ew;
      e.res   = er;
      e.err   = ee;
      e.lat   = lat;
      sb.push_back(e);
    end
    cmd_op    = op;
    cmd_arg   = arg[7:0];
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd2;
    cmd_arg   = 8'hFF;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) break;
    end
    if (n >= 400) chk("idle_timeout", n, 0);
  endtask

  initial begin
    automatic int seq[5] = '{14, 15, 0, 1, 2};
    automatic int dcnt = 0;
    rst       = 1'b1;
    fault     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_arg   = 8'd0;
    sb.push_back('{0, 0, 0, 0});
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_preload", int'(preload), 0);
    chk("rst_pval", int'(preload_val), 0);
    chk("rst_rspv", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle();

    issue(2'd1, 9, 1, 0, 9, 0, 2);
    chk("pl9_pulse", int'(preload), 1);
    chk("pl9_val", int'(preload_val), 9);
    chk("pl9_en", int'(enable), 0);
    @(posedge clk);
    #1;
    chk("pl9_drop", int'(preload), 0);
    chk("pl9_hold", int'(preload_val), 9);
    wait_idle();

    issue(2'd1, 13, 1, 0, 13, 0, 2);
    wait_idle();
    issue(2'd2, 5, 1, 1, 2, 0, 6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("run5_res", int'(result), seq[i]);
      if (detect) dcnt++;
    end
    chk("run5_detect_cnt", dcnt, 1);
    wait_idle();

    issue(2'd1, 0, 1, 0, 0, 0, 2);
    wait_idle();
    issue(2'd2, 40, 1, 2, 8, 0, 41);
    wait_idle();
    issue(2'd3, 6, 1, 0, 8, 0, 7);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("hold_res", int'(result), 8);
      chk("hold_en", int'(enable), 0);
    end
    wait_idle();
    issue(2'd3, 0, 1, 0, 8, 0, 1);
    wait_idle();
    issue(2'd2, 0, 1, 0, 8, 0, 1);
    wait_idle();

    fault = 1'b1;
    issue(2'd1, 3, 1, 0, 2, 1, 2);
    wait_idle();
    fault = 1'b0;
    issue(2'd1, 2, 1, 0, 2, 0, 2);
    wait_idle();
    issue(2'd1, 3, 1, 0, 3, 0, 2);
    wait_idle();
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    issue(2'd0, 0, 1, 0, 3, 1, 0);
    wait_idle();
    issue(2'd0, 0, 1, 0, 3, 0, 0);
    wait_idle();

    issue(2'd2, 10, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort_pre_en", int'(enable), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_en", int'(enable), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready_rst", int'(cmd_ready), 0);
    chk("abort_cnt", int'(result), 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_exp", int'(dut.w_exp), 0);
    acc_q.delete();
    repeat (4) @(negedge clk);
    issue(2'd0, 0, 1, 0, 0, 0, 0);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=%0d want=0",
             cyc);
    $fatal(1, "timeout");
  end

endmodule
